// File: rtl/bcd_digit_decoder.sv
// Splits a packed multi-digit BCD word into per-digit 10-bit one-hot codes,
// least-significant digit first, one digit per output handshake.
module bcd_digit_decoder #(
  parameter int NUM_DIGITS = 4,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_bcd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [9:0]              out_onehot,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    out_err,
  output logic                    word_err,
  output logic                    dbg_state
);

  // Handshake rule (both ports): a transfer happens on a rising edge where
  // valid and ready are both high; once valid is raised, the presented data
  // and valid are held unchanged until that transfer.

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [9:0]              onehot_q, onehot_d;
  logic                    last_q, last_d;
  logic                    err_q, err_d;
  logic                    werr_q, werr_d;
  logic [IDX_W-1:0]        idx_next;
  logic [3:0]              nib;

  function automatic logic [9:0] decode(input logic [3:0] v);
    if (v <= 4'd9) return 10'd1 << v;
    return 10'd0;
  endfunction

  assign idx_next = idx_q + 1'b1;

  // pend_q holds only the digits not yet presented; the current one lives in
  // the output registers.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    last_d   = last_q;
    err_d    = err_q;
    werr_d   = werr_q;
    nib      = 4'd0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          nib      = in_bcd[3:0];
          state_d  = EMIT;
          pend_d   = in_bcd >> 4;
          idx_d    = '0;
          onehot_d = decode(nib);
          err_d    = (nib > 4'd9);
          last_d   = (NUM_DIGITS == 1);
          werr_d   = (nib > 4'd9);
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            state_d  = IDLE;
            idx_d    = '0;
            onehot_d = '0;
            last_d   = 1'b0;
            err_d    = 1'b0;
          end else begin
            nib      = pend_q[3:0];
            pend_d   = pend_q >> 4;
            idx_d    = idx_next;
            onehot_d = decode(nib);
            err_d    = (nib > 4'd9);
            last_d   = (idx_next == IDX_W'(NUM_DIGITS - 1));
            werr_d   = werr_q | (nib > 4'd9);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      idx_q    <= '0;
      onehot_q <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      werr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      last_q   <= last_d;
      err_q    <= err_d;
      werr_q   <= werr_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == EMIT);
  assign out_onehot = onehot_q;
  assign out_idx    = idx_q;
  assign out_last   = last_q;
  assign out_err    = err_q;
  assign word_err   = werr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bcd_digit_decoder.sv
// Randomized and directed bench for bcd_digit_decoder, checked every cycle
// against a digit-queue reference model.
module tb_bcd_digit_decoder;

  localparam int N = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4*N-1:0] in_bcd = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [9:0]    out_onehot;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_err;
  logic          word_err;
  logic          dbg_state;

  logic          in_valid1 = 1'b0;
  logic          in_ready1;
  logic [3:0]    in_bcd1 = '0;
  logic          out_valid1;
  logic          out_ready1 = 1'b0;
  logic [9:0]    out_onehot1;
  logic [0:0]    out_idx1;
  logic          out_last1;
  logic          out_err1;
  logic          word_err1;
  logic          dbg_state1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [3:0] exp_q[$];
  logic       m_werr = 1'b0;

  always #5 clk = ~clk;

  bcd_digit_decoder #(.NUM_DIGITS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_bcd(in_bcd), .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_idx(out_idx), .out_last(out_last),
    .out_err(out_err), .word_err(word_err), .dbg_state(dbg_state)
  );

  bcd_digit_decoder #(.NUM_DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_bcd(in_bcd1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_onehot(out_onehot1), .out_idx(out_idx1), .out_last(out_last1),
    .out_err(out_err1), .word_err(word_err1), .dbg_state(dbg_state1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word becomes a queue of pending digits; the front is
  // what must be on the outputs.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_werr = 1'b0;
    end else if (exp_q.size() != 0) begin
      if (out_ready) begin
        m_werr = m_werr | (exp_q[0] > 4'd9);
        void'(exp_q.pop_front());
      end
    end else if (in_valid) begin
      for (int k = 0; k < N; k++) exp_q.push_back(in_bcd[4*k +: 4]);
      m_werr = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("m_ready", 32'(in_ready), 32'(exp_q.size() == 0));
      if (exp_q.size() != 0) begin
        chk("m_onehot", 32'(out_onehot), (exp_q[0] <= 4'd9) ? (32'd1 << exp_q[0]) : 32'd0);
        chk("m_err", 32'(out_err), 32'(exp_q[0] > 4'd9));
        chk("m_idx", 32'(out_idx), 32'(N - exp_q.size()));
        chk("m_last", 32'(out_last), 32'(exp_q.size() == 1));
        chk("m_werr", 32'(word_err), 32'(m_werr | (exp_q[0] > 4'd9)));
      end else begin
        chk("m_werr_idle", 32'(word_err), 32'(m_werr));
      end
    end
  end

  task automatic send(input logic [15:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    in_bcd = w;
    @(negedge clk);
    in_valid = 1'b0;
    in_bcd = $urandom_range(0, 65535);
  endtask

  function automatic logic [3:0] rand_nib();
    if ($urandom_range(0, 3) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  logic [9:0] t2_oh [6] = '{10'h080, 10'h001, 10'h001, 10'h001, 10'h200, 10'h001};
  bit         t2_rd [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [9:0] t3_oh [4] = '{10'h000, 10'h020, 10'h000, 10'h008};
  int         nvalid;

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_outs", {20'(out_onehot), 2'(out_idx), out_last, out_err, word_err}, 32'd0);

    // Directed 1: 1234, out_ready high
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_bcd = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk("t1_onehot", 32'(out_onehot), 32'(10'h010 >> i));
      chk("t1_idx", 32'(out_idx), i);
      chk("t1_last", 32'(out_last), 32'(i == 3));
      chk("t1_ready_low", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    chk("t1_ready_back", 32'(in_ready), 32'd1);

    // Directed 2: stalls on 0907
    in_valid = 1'b1;
    in_bcd = 16'h0907;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk("t2_onehot", 32'(out_onehot), 32'(t2_oh[i]));
      out_ready = t2_rd[i];
    end
    @(negedge clk);
    chk("t2_done", 32'(out_valid), 32'd0);

    // Directed 3: invalid nibbles in 3A5F, then clear with 0000
    in_valid = 1'b1;
    in_bcd = 16'h3A5F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk("t3_onehot", 32'(out_onehot), 32'(t3_oh[i]));
      chk("t3_err", 32'(out_err), 32'(i % 2 == 0));
      chk("t3_werr", 32'(word_err), 32'd1);
    end
    @(negedge clk);
    chk("t3_werr_idle", 32'(word_err), 32'd1);
    in_valid = 1'b1;
    in_bcd = 16'h0000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t3_werr_clear", 32'(word_err), 32'd0);
    repeat (4) @(negedge clk);

    // Directed 4: reset mid-word
    in_valid = 1'b1;
    in_bcd = 16'h9876;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_idx2", 32'(out_idx), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_ready", 32'(in_ready), 32'd1);
    chk("t4_outs", {20'(out_onehot), 2'(out_idx), out_last, out_err, word_err}, 32'd0);
    in_valid = 1'b1;
    in_bcd = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t4_new", {22'(out_onehot), 2'(out_idx)}, {22'h002, 2'd0});
    repeat (4) @(negedge clk);

    // Directed 5: back-to-back words with in_valid held high
    nvalid = 0;
    in_valid = 1'b1;
    in_bcd = 16'h1111;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) in_bcd = 16'h2222;
      if (out_valid) nvalid++;
      if (i == 5) chk("t5_gap_ready", 32'(in_ready), 32'd1);
      if (i == 6) begin
        in_valid = 1'b0;
        chk("t5_second", 32'(out_onehot), 32'h004);
      end
    end
    chk("t5_count", nvalid, 8);

    // Directed 6: single-digit build
    in_valid1 = 1'b1;
    in_bcd1 = 4'h9;
    out_ready1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("t6_valid", 32'(out_valid1), 32'd1);
    chk("t6_onehot", 32'(out_onehot1), 32'h200);
    chk("t6_last_idx", {out_last1, out_idx1, in_ready1}, 32'b100);
    @(negedge clk);
    chk("t6_ready", {out_valid1, in_ready1}, 32'b01);
    in_valid1 = 1'b1;
    in_bcd1 = 4'hC;
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("t6_err", {out_err1, word_err1, 20'(out_onehot1)}, {2'b11, 20'd0});

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) in_bcd[4*k +: 4] = rand_nib();
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
